differentiator_core: RTL and testbench
======================================

# differentiator_core

Comb/differentiator stage that undoes `integrator_core`: it consumes the wrapping signed accumulator stream on a one-cycle strobe, optionally decimates by R, and outputs the differential-delay difference y[n] = x[n] − x[n−M] (M = 1 or 2). The difference is then arithmetically scaled and saturated or truncated to the output width. It sits downstream of the integrator and completes an integrator→differentiator (CIC-style) chain. The output is a registered sample with a one-cycle valid pulse.

## Interface
- ACC_W, 16, input sample width (signed, two's complement, wraps)
- OUT_W, 8, output sample width (signed); OUT_W ≤ ACC_W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  global enable; low freezes all state
- clear  in  1  synchronous flush of counter, delay line, priming state
- sample_strobe  in  1  one-cycle pulse accepting acc_in
- acc_in  in  ACC_W  signed accumulator sample
- decim_ratio  in  8  decimation ratio R; 0 treated as 1
- diff_delay  in  1  0: M=1, 1: M=2
- out_shift  in  4  arithmetic right shift applied to difference (0..15)
- sat_enable  in  1  1: clamp to OUT_W range, 0: truncate (wrap)
- diff_out  out  OUT_W  signed result, held between updates
- out_valid  out  1  one-cycle pulse when diff_out updates
- primed  out  1  high once ≥ M decimated samples are stored
- overflow_flag  out  1  set if the last output was clamped or truncated with value change

## Operation
- An accepted sample is sample_strobe=1 & enable=1 & clear=0.
- Decimation counter dcnt is 8 bits and resets to 0. On each accepted sample: if dcnt ≥ R−1, the sample is decimated and dcnt ← 0; otherwise dcnt ← dcnt+1. Using ≥ makes a mid-count reduction of R wrap safely.
- Delay line: d1 (last decimated sample) and d2 (previous). On a decimated sample, d2 ← d1 and d1 ← acc_in.
- Priming counter pcnt saturates at 2 and increments per decimated sample. primed = (pcnt ≥ M).
- Output: on a decimated sample with pcnt ≥ M (pre-update value), diff = acc_in − (M=1 ? d1 : d2), computed modulo 2^ACC_W. Wrap in the integrator therefore cancels when the true difference fits in ACC_W.
- Scaling: s = diff >>> out_shift, sign-preserving.
- Width reduction:
  - sat_enable=1: clamp s to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; overflow_flag ← 1 if clamped, else 0.
  - sat_enable=0: keep the low OUT_W bits; overflow_flag ← 1 if the discarded bits are not a sign extension, else 0.
- overflow_flag updates only with out_valid and holds otherwise.
- A decimated sample with pcnt < M updates the delay line and pcnt but produces no output.
- diff_delay is sampled per decimated sample. Switching 0→1 with pcnt=1 suppresses output until pcnt=2.
- enable=0: dcnt, d1, d2, pcnt and outputs hold; out_valid=0; strobes are ignored.
- clear=1 (with enable don't-care): dcnt, pcnt, d1, d2 ← 0; primed ← 0; out_valid ← 0; diff_out and overflow_flag hold. Clear wins over a simultaneous strobe, and that sample is dropped.

## Timing
- Reset values: diff_out=0, out_valid=0, primed=0, overflow_flag=0; dcnt=pcnt=d1=d2=0.
- Latency: out_valid and diff_out are registered in the cycle after the accepted strobe edge, i.e. visible one clk after the strobe.
- Throughput: one sample per cycle; back-to-back strobes are legal.
- primed updates on the same edge as pcnt.
- Reset asserted mid-operation: all state returns to reset values asynchronously. The first sample after release counts as dcnt=0.

## Structure
- Shared package `integrator_pkg`: default ACC_W/OUT_W constants and a `sat_trunc` function (signed clamp/truncate plus overflow bit) that `integrator_core` can reuse.
- One combinational sub-module, `diff_scale_sat`: shift plus saturate/truncate producing {value, ovf}. Everything else lives in the top.

## Test plan
- R=1, M=1, sat_enable=1, shift=0; acc_in 0, 5, 10, 15 on consecutive strobes → no output for 0; diff_out 5, 5, 5 with out_valid pulses one cycle after each strobe; primed high after the first sample.
- Wrap: R=1, M=1, acc_in 32760 then −32766 → diff_out 10, overflow_flag 0.
- Saturation: differences of 300 then −300, shift=0. sat_enable=1 → 127 then −128, overflow_flag 1. sat_enable=0 → 44 then −44, overflow_flag 1. A following difference of 20 → 20, flag 0.
- Decimation: R=4, M=2, acc_in 0, 3, 6, … on 12 strobes → decimated samples 9, 21, 33; one output of 24 (33 − 9) after the 12th strobe. R=0 behaves as R=1.
- Control: enable=0 during strobes → no state change. clear together with a strobe → sample dropped, primed 0, next two samples re-prime (M=1: first output on the second sample).
- Reset mid-stream, with rst_n low for 3 cycles while strobing → all outputs 0; after release, behaviour matches a fresh start with dcnt=0.

Source files
------------

// File: rtl/integrator_pkg.sv
// Shared definitions for the integrator -> differentiator (CIC-style) chain.
// Provides the default sample widths and the sat_trunc helper. sat_trunc
// reduces a signed value to out_w bits, either by clamping or by plain
// truncation, and also returns an overflow bit. The helper works on a
// fixed-width container so both cores can call it for any width up to MAXW.
package integrator_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int OUT_W_DEF = 8;
  localparam int MAXW      = 32;   // widest sample either core may use

  typedef struct packed {
    logic signed [MAXW-1:0] val;
    logic                   ovf;
  } sat_res_t;

  // The result value is sign-extended to MAXW. For every legal out_w, the
  // low out_w bits hold the reduced sample.
  function automatic sat_res_t sat_trunc(input logic signed [MAXW-1:0] x,
                                         input int unsigned            out_w,
                                         input logic                   sat);
    sat_res_t             r;
    logic signed [MAXW:0] xe;
    logic signed [MAXW:0] one;
    logic signed [MAXW:0] hi;
    logic signed [MAXW:0] lo;
    logic signed [MAXW-1:0] t;
    int unsigned          sh;
    // Bounds are one bit wider than the input so that out_w == MAXW
    // does not overflow.
    one = {{MAXW{1'b0}}, 1'b1};
    xe  = {x[MAXW-1], x};
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -(one <<< (out_w - 1));
    sh  = MAXW - out_w;
    // Truncation: keep the low out_w bits and re-extend their sign.
    t   = (x <<< sh) >>> sh;
    r.val = x;
    r.ovf = 1'b0;
    if (sat) begin
      if (xe > hi) begin
        r.val = hi[MAXW-1:0];
        r.ovf = 1'b1;
      end else if (xe < lo) begin
        r.val = lo[MAXW-1:0];
        r.ovf = 1'b1;
      end
    end else begin
      r.val = t;
      r.ovf = (t != x);
    end
    return r;
  endfunction

endpackage

// File: rtl/diff_scale_sat.sv
// Combinational output stage of the differentiator.
// It arithmetically right-shifts the ACC_W-bit difference and then reduces
// the result to OUT_W bits, by clamping or by truncation.
//   diff_i   : signed difference (ACC_W)
//   shift_i  : arithmetic right-shift amount, 0..15
//   sat_en_i : 1 = clamp, 0 = truncate (wrap)
//   value_o  : signed reduced sample (OUT_W)
//   ovf_o    : 1 if clamped, or if truncation changed the value
module diff_scale_sat
  import integrator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] diff_i,
  input  logic        [3:0]       shift_i,
  input  logic                    sat_en_i,
  output logic signed [OUT_W-1:0] value_o,
  output logic                    ovf_o
);

  logic signed [ACC_W-1:0] scaled;
  sat_res_t                res;

  assign scaled  = diff_i >>> shift_i;
  assign res     = sat_trunc(MAXW'(scaled), OUT_W, sat_en_i);
  assign value_o = res.val[OUT_W-1:0];
  assign ovf_o   = res.ovf;

endmodule

// File: rtl/differentiator_core.sv
// Comb (differentiator) stage that undoes integrator_core.
// On each accepted strobe it optionally decimates by R. For each decimated
// sample it outputs y = x[n] - x[n-M] (M = 1 or 2), computed modulo
// 2^ACC_W, then scaled and saturated or truncated to OUT_W bits.
//   clk, rst_n         : clock, asynchronous active-low reset
//   enable, clear      : global freeze; synchronous flush (clear wins)
//   sample_strobe      : one-cycle pulse; acc_in is valid with it
//   acc_in             : wrapping signed accumulator sample
//   decim_ratio        : R (0 is treated as 1)
//   diff_delay         : 0 -> M=1, 1 -> M=2
//   out_shift          : arithmetic right shift of the difference
//   sat_enable         : 1 = clamp, 0 = truncate
//   diff_out/out_valid : registered result and one-cycle update pulse
//   primed             : at least M decimated samples are stored
//   overflow_flag      : the last output was clamped or changed by truncation
module differentiator_core
  import integrator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    sample_strobe,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic        [7:0]       decim_ratio,
  input  logic                    diff_delay,
  input  logic        [3:0]       out_shift,
  input  logic                    sat_enable,
  output logic signed [OUT_W-1:0] diff_out,
  output logic                    out_valid,
  output logic                    primed,
  output logic                    overflow_flag
);

  logic        [7:0]       dcnt_q, dcnt_d;
  logic        [1:0]       pcnt_q, pcnt_d;
  logic signed [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic signed [OUT_W-1:0] diff_out_q, diff_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;

  logic        [7:0]       r_m1;
  logic        [1:0]       m_val;
  logic                    accept, decim, emit;
  logic signed [ACC_W-1:0] diff;
  logic signed [OUT_W-1:0] red_val;
  logic                    red_ovf;

  assign r_m1   = (decim_ratio == 8'd0) ? 8'd0 : decim_ratio - 8'd1;
  assign m_val  = diff_delay ? 2'd2 : 2'd1;
  assign accept = sample_strobe & enable & ~clear;
  // Using >= here means that lowering R mid-count still decimates on the
  // next accepted sample instead of counting around 256.
  assign decim  = accept & (dcnt_q >= r_m1);
  assign emit   = decim & (pcnt_q >= m_val);
  // The subtraction is modulo 2^ACC_W, so wrap in the integrator cancels.
  assign diff   = acc_in - (diff_delay ? d2_q : d1_q);
  assign primed = (pcnt_q >= m_val);

  diff_scale_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_scale (
    .diff_i   (diff),
    .shift_i  (out_shift),
    .sat_en_i (sat_enable),
    .value_o  (red_val),
    .ovf_o    (red_ovf)
  );

  always_comb begin
    dcnt_d      = dcnt_q;
    pcnt_d      = pcnt_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    diff_out_d  = diff_out_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (clear) begin
      dcnt_d = '0;
      pcnt_d = '0;
      d1_d   = '0;
      d2_d   = '0;
    end else if (accept) begin
      dcnt_d = decim ? 8'd0 : dcnt_q + 8'd1;
      if (decim) begin
        d2_d = d1_q;
        d1_d = acc_in;
        if (pcnt_q != 2'd2) pcnt_d = pcnt_q + 2'd1;
      end
      if (emit) begin
        diff_out_d  = red_val;
        ovf_d       = red_ovf;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q      <= '0;
      pcnt_q      <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      diff_out_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      dcnt_q      <= dcnt_d;
      pcnt_q      <= pcnt_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      diff_out_q  <= diff_out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign diff_out      = diff_out_q;
  assign out_valid     = out_valid_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_differentiator_core.sv
module tb_differentiator_core;

  localparam int ACC_W = 16;
  localparam int OUT_W = 8;
  localparam int OMAX  = 127;
  localparam int OMIN  = -128;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic                    clear;
  logic                    sample_strobe;
  logic signed [ACC_W-1:0] acc_in;
  logic        [7:0]       decim_ratio;
  logic                    diff_delay;
  logic        [3:0]       out_shift;
  logic                    sat_enable;
  logic signed [OUT_W-1:0] diff_out;
  logic                    out_valid;
  logic                    primed;
  logic                    overflow_flag;

  differentiator_core #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .clear         (clear),
    .sample_strobe (sample_strobe),
    .acc_in        (acc_in),
    .decim_ratio   (decim_ratio),
    .diff_delay    (diff_delay),
    .out_shift     (out_shift),
    .sat_enable    (sat_enable),
    .diff_out      (diff_out),
    .out_valid     (out_valid),
    .primed        (primed),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a history of the decimated samples, plus the number
  // of samples seen since the last decimation.
  int hist[$];
  int since;
  int e_out;
  bit e_ovf;
  bit e_vld;

  task automatic model_reset();
    hist.delete();
    since = 0;
    e_out = 0;
    e_ovf = 1'b0;
    e_vld = 1'b0;
  endtask

  task automatic model_edge();
    int r, m, a, d, s, p, t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_vld = 1'b0;
    if (clear) begin
      hist.delete();
      since = 0;
      return;
    end
    if (!(enable && sample_strobe)) return;
    r = (decim_ratio == 0) ? 1 : int'(decim_ratio);
    if (since + 1 < r) begin
      since++;
      return;
    end
    since = 0;
    a = int'(acc_in);
    m = diff_delay ? 2 : 1;
    if (hist.size() >= m) begin
      d = a - hist[hist.size() - m];
      d = ((d + 32768) & 65535) - 32768;
      p = 1 << int'(out_shift);
      if (d >= 0) s = d / p;
      else        s = -((-d + p - 1) / p);
      if (sat_enable) begin
        if (s > OMAX)      begin e_out = OMAX; e_ovf = 1'b1; end
        else if (s < OMIN) begin e_out = OMIN; e_ovf = 1'b1; end
        else               begin e_out = s;    e_ovf = 1'b0; end
      end else begin
        t = s & 255;
        if (t >= 128) t -= 256;
        e_out = t;
        e_ovf = (t != s);
      end
      e_vld = 1'b1;
    end
    hist.push_back(a);
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  task automatic check_all(input string tag);
    int m;
    bit e_primed;
    m = diff_delay ? 2 : 1;
    e_primed = (hist.size() >= m);
    tests++;
    assert (out_valid === e_vld) else begin
      fails++;
      $error("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, e_vld);
    end
    tests++;
    assert (int'(diff_out) === e_out) else begin
      fails++;
      $error("FAIL %s diff_out: got %0d expected %0d", tag, diff_out, e_out);
    end
    tests++;
    assert (overflow_flag === e_ovf) else begin
      fails++;
      $error("FAIL %s overflow_flag: got %0b expected %0b", tag, overflow_flag, e_ovf);
    end
    tests++;
    assert (primed === e_primed) else begin
      fails++;
      $error("FAIL %s primed: got %0b expected %0b", tag, primed, e_primed);
    end
  endtask

  task automatic step(input string tag, input bit stb, input int a);
    sample_strobe = stb;
    acc_in        = ACC_W'(a);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Checks against literal values worked out by hand from the rules.
  task automatic expect_out(input string tag, input bit v, input int val, input bit o);
    tests++;
    assert (out_valid === v && int'(diff_out) === val && overflow_flag === o) else begin
      fails++;
      $error("FAIL %s: got vld=%0b out=%0d ovf=%0b expected vld=%0b out=%0d ovf=%0b",
             tag, out_valid, diff_out, overflow_flag, v, val, o);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step("clear", 1'b0, 0);
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; sample_strobe = 1'b0; acc_in = '0;
    decim_ratio = 8'd1; diff_delay = 1'b0; out_shift = 4'd0; sat_enable = 1'b1;
    step("reset", 1'b0, 0);
    step("reset", 1'b0, 0);
    expect_out("reset_vals", 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    step("idle", 1'b0, 0);

    // Basic ramp, R=1, M=1.
    step("ramp0", 1'b1, 0);
    expect_out("ramp0_noout", 1'b0, 0, 1'b0);
    step("ramp1", 1'b1, 5);  expect_out("ramp1", 1'b1, 5, 1'b0);
    step("ramp2", 1'b1, 10); expect_out("ramp2", 1'b1, 5, 1'b0);
    step("ramp3", 1'b1, 15); expect_out("ramp3", 1'b1, 5, 1'b0);
    step("ramp_idle", 1'b0, 0);
    expect_out("ramp_hold", 1'b0, 5, 1'b0);

    // Integrator wrap cancels.
    do_clear();
    step("wrap0", 1'b1, 32760);
    step("wrap1", 1'b1, -32766); expect_out("wrap", 1'b1, 10, 1'b0);

    // Saturation and truncation.
    do_clear();
    step("sat0", 1'b1, 0);
    step("sat1", 1'b1, 300); expect_out("sat_pos", 1'b1, 127, 1'b1);
    step("sat2", 1'b1, 0);   expect_out("sat_neg", 1'b1, -128, 1'b1);
    sat_enable = 1'b0;
    step("trn1", 1'b1, 300); expect_out("trunc_pos", 1'b1, 44, 1'b1);
    step("trn2", 1'b1, 0);   expect_out("trunc_neg", 1'b1, -44, 1'b1);
    step("trn3", 1'b1, 20);  expect_out("trunc_fit", 1'b1, 20, 1'b0);
    sat_enable = 1'b1;

    // Decimation R=4, M=2.
    do_clear();
    decim_ratio = 8'd4; diff_delay = 1'b1;
    for (int i = 0; i < 12; i++) step("decim", 1'b1, 3 * i);
    expect_out("decim_out", 1'b1, 24, 1'b0);
    step("decim_idle", 1'b0, 0);

    // R=0 behaves as R=1.
    do_clear();
    decim_ratio = 8'd0; diff_delay = 1'b0;
    step("r0_a", 1'b1, 7);
    step("r0_b", 1'b1, 9); expect_out("r0", 1'b1, 2, 1'b0);

    // Enable low ignores strobes.
    enable = 1'b0;
    step("dis0", 1'b1, 100);
    step("dis1", 1'b1, 200);
    enable = 1'b1;
    step("en", 1'b1, 12); expect_out("after_enable", 1'b1, 3, 1'b0);

    // Clear together with a strobe drops that sample.
    clear = 1'b1;
    step("clr_stb", 1'b1, 50);
    clear = 1'b0;
    step("reprime0", 1'b1, 60); expect_out("reprime0", 1'b0, 3, 1'b0);
    step("reprime1", 1'b1, 65); expect_out("reprime1", 1'b1, 5, 1'b0);

    // Asynchronous reset mid-stream with R=3.
    decim_ratio = 8'd3;
    step("pre_rst0", 1'b1, 1);
    step("pre_rst1", 1'b1, 2);
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) step("in_rst", 1'b1, 70 + i);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("post_rst", 1'b1, 10 * i);
    expect_out("post_rst", 1'b1, 30, 1'b0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) decim_ratio = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0)  diff_delay  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  out_shift   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)  sat_enable  = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 29) == 0);
      step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)) - 32768);
    end
    clear = 1'b0;
    enable = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
